// File: rtl/reg_bank_pkg.sv
// Shared definitions for the four-entry register bank feeding the 4-to-1 datapath mux.
//   WIDTH      : data width of each entry and of the mux output
//   NREGS      : entry count (fixed at 4 because the mux select is 2 bits)
//   state_t    : scan sequencer states
package reg_bank_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank4x16_if.sv
// Bus bundle between the register bank and its user.
//   write side : wr_en, wr_addr, wr_data, clr_all
//   read side  : rd_addr, a, b, c, d, sel, out
//   scan side  : scan_start, scan_busy, scan_valid, scan_idx, scan_done
// master drives requests and observes results; slave is the register bank.
interface reg_bank4x16_if;
  import reg_bank_pkg::*;

  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_all;
  logic [1:0]       rd_addr;
  logic             scan_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             scan_busy;
  logic             scan_valid;
  logic [1:0]       scan_idx;
  logic             scan_done;

  modport master (
    output wr_en, wr_addr, wr_data, clr_all, rd_addr, scan_start,
    input  a, b, c, d, sel, out, scan_busy, scan_valid, scan_idx, scan_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_all, rd_addr, scan_start,
    output a, b, c, d, sel, out, scan_busy, scan_valid, scan_idx, scan_done
  );

endinterface

// File: rtl/mux4way16.sv
// 16-bit 4-to-1 multiplexer of the CPU datapath.
//   a, b, c, d : data inputs (sel = 0, 1, 2, 3)
//   sel        : 2-bit select
//   out        : selected input
module mux4way16
  import reg_bank_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/reg_bank4x16.sv
// Four-entry register bank driving the datapath mux, with a scan sequencer
// that streams entries 0..3 out through the mux for register dump.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset (aborts any scan)
//   bus : slave side of reg_bank4x16_if (writes, clear, reads, scan control/status)
module reg_bank4x16
  import reg_bank_pkg::*;
(
  input logic            clk,
  input logic            rst,
  reg_bank4x16_if.slave  bus
);

  logic [WIDTH-1:0] regs [NREGS];
  state_t           state, state_next;
  logic [1:0]       idx, idx_next;

  // Storage: clear wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_all) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wr_en) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Scan start is only honoured in IDLE or DONE; it is never queued during SCAN.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (bus.scan_start) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        if (idx == 2'd3) state_next = DONE;
        else             idx_next   = idx + 2'd1;
      end
      DONE: begin
        if (bus.scan_start) begin
          state_next = SCAN;
          idx_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.a          = regs[0];
  assign bus.b          = regs[1];
  assign bus.c          = regs[2];
  assign bus.d          = regs[3];
  assign bus.scan_busy  = (state == SCAN);
  assign bus.scan_valid = (state == SCAN);
  assign bus.scan_done  = (state == DONE);
  assign bus.scan_idx   = idx;
  assign bus.sel        = (state == SCAN) ? idx : bus.rd_addr;

  mux4way16 u_mux (
    .a   (regs[0]),
    .b   (regs[1]),
    .c   (regs[2]),
    .d   (regs[3]),
    .sel (bus.sel),
    .out (bus.out)
  );

endmodule

// File: tb/tb_reg_bank4x16.sv
// Self-checking bench for reg_bank4x16: directed scenarios followed by random
// traffic, checked against a behavioural model of the bank and scan sequence.
module tb_reg_bank4x16;
  import reg_bank_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank4x16_if bus ();

  reg_bank4x16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_regs [4];
  int          m_phase;   // -1 idle, 0..3 scanning that entry, 4 done pulse
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One clock cycle: apply inputs, advance the model, check the DUT after the edge.
  task automatic step(input logic r, input logic we, input logic [1:0] wa,
                      input logic [15:0] wd, input logic clr, input logic [1:0] ra,
                      input logic st);
    rst            = r;
    bus.wr_en      = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.clr_all    = clr;
    bus.rd_addr    = ra;
    bus.scan_start = st;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
      m_phase = -1;
    end else begin
      if (clr) for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
      else if (we) m_regs[wa] = wd;
      if (m_phase == -1 || m_phase == 4) m_phase = st ? 0 : -1;
      else m_phase = m_phase + 1;
    end
    #1;
    if (m_phase >= 0 && m_phase <= 3) q.push_back('{m_phase, m_regs[m_phase]});
    chk("a", bus.a, m_regs[0]);
    chk("b", bus.b, m_regs[1]);
    chk("c", bus.c, m_regs[2]);
    chk("d", bus.d, m_regs[3]);
    chk("scan_busy", bus.scan_busy, (m_phase >= 0 && m_phase <= 3));
    chk("scan_done", bus.scan_done, (m_phase == 4));
    if (!(m_phase >= 0 && m_phase <= 3)) begin
      chk("sel_idle", bus.sel, ra);
      chk("out_read", bus.out, m_regs[ra]);
    end
  endtask

  task automatic idle(input logic [1:0] ra);
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, ra, 1'b0);
  endtask

  // Scoreboard monitor: every cycle the DUT flags scan_valid, pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (bus.scan_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("scan_unexpected", bus.scan_valid, 0);
      end else begin
        e = q.pop_front();
        chk("scan_idx", bus.scan_idx, e.idx);
        chk("scan_out", bus.out, e.data);
      end
    end
  end

  initial begin
    m_phase = -1;
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;

    // Reset for two cycles, then read every entry.
    step(1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) idle(2'(i));

    // Writes, each read back on the following cycle.
    step(1'b0, 1'b1, 2'd0, 16'h1111, 1'b0, 2'd0, 1'b0);
    idle(2'd0);
    step(1'b0, 1'b1, 2'd1, 16'h2222, 1'b0, 2'd1, 1'b0);
    idle(2'd1);
    step(1'b0, 1'b1, 2'd2, 16'h3333, 1'b0, 2'd2, 1'b0);
    idle(2'd2);
    step(1'b0, 1'b1, 2'd3, 16'hBEEF, 1'b0, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) idle(2'(i));

    // Plain scan with rd_addr held at 2.
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd2, 1'b1);
    for (int i = 0; i < 6; i++) idle(2'd2);

    // Scan with a redundant start in cycle 2, then back-to-back restart from DONE.
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 1'b1);
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 2; i++) idle(2'd1);
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 1'b1);
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) idle(2'd0);

    // Write entry 3 while the scan is in progress; seen when entry 3 is scanned.
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b1);
    idle(2'd0);
    step(1'b0, 1'b1, 2'd3, 16'h5A5A, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) idle(2'd3);

    // Clear and write in the same cycle: clear wins.
    step(1'b0, 1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) idle(2'(i));

    // Reset in scan cycle 3, then a clean scan afterwards.
    step(1'b0, 1'b1, 2'd2, 16'hC0DE, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 1'b1);
    idle(2'd0);
    idle(2'd0);
    step(1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd2, 1'b0);
    idle(2'd2);
    step(1'b0, 1'b1, 2'd1, 16'h7777, 1'b0, 2'd1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 1'b1);
    for (int i = 0; i < 6; i++) idle(2'd3);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom), 16'($urandom),
           $urandom_range(0, 19) == 0, 2'($urandom), $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 6; i++) idle(2'(i));

    @(negedge clk);
    #1;
    chk("scan_queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_bank4x16.md
# reg_bank4x16

Four-entry, 16-bit register bank directly upstream of the 16-bit 4-to-1 multiplexer in the CPU datapath. It holds the four operands that drive the mux's `a`, `b`, `c` and `d` inputs and generates the mux select. It also runs a scan sequencer that streams all four entries out through the mux in order, for register dump and debug. Writes, clears and reads all share one clock domain.

## Interface
- `WIDTH`, 16: data width of each entry and of `out`.
- `NREGS`, 4: entry count. Fixed at 4 because the select is 2 bits; any other value is unsupported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  2  write index.
- `wr_data`  in  16  write data.
- `clr_all`  in  1  synchronous clear of all four entries.
- `rd_addr`  in  2  read index used while the sequencer is idle.
- `scan_start`  in  1  request a four-entry scan.
- `a`, `b`, `c`, `d`  out  16 each  registered entries 0 to 3, wired to the mux inputs.
- `sel`  out  2  mux select.
- `out`  out  16  selected entry, produced by the internal mux.
- `scan_busy`  out  1  high while the sequencer is in SCAN.
- `scan_valid`  out  1  `out` holds scan entry `scan_idx` this cycle.
- `scan_idx`  out  2  entry index currently being scanned.
- `scan_done`  out  1  one-cycle pulse after the last scan entry.

## Operation
- **Storage:** four WIDTH-bit flops.
  - `wr_en` writes `wr_data` into entry `wr_addr`.
  - `clr_all` zeroes all four entries.
  - `clr_all` has priority over `wr_en` in the same cycle; the write is lost.
- **Select:** `sel = scan_idx` while in SCAN, otherwise `sel = rd_addr`. `out = entry[sel]`, combinational from registered state.
- **FSM states:** IDLE, SCAN, DONE.
  - IDLE → SCAN when `scan_start`=1; `scan_idx` loads 0.
  - SCAN: `scan_idx` increments every cycle. After index 3 the FSM goes to DONE; there is no wrap to 0 inside SCAN.
  - DONE → SCAN when `scan_start`=1, with `scan_idx`=0. Otherwise DONE → IDLE.
  - `scan_start` while in SCAN is ignored. It is not queued.
- **Decoded outputs:**
  - `scan_busy` = (state == SCAN).
  - `scan_valid` = (state == SCAN).
  - `scan_done` = (state == DONE).
- **Writes during a scan:** permitted. A write in cycle N is visible on `a`–`d` and `out` from cycle N+1. A scan therefore shows the new value only if the written entry is scanned after the write cycle.
- **Reset:**
  - All entries go to 0, the FSM to IDLE, `scan_idx` to 0.
  - `scan_busy`, `scan_valid` and `scan_done` go to 0. `sel` = `rd_addr`.
  - Reset mid-scan aborts the scan with no `scan_done` pulse.
  - `rst` has priority over `clr_all`, `wr_en` and `scan_start`.

## Timing
- Write latency is 1 cycle, from the `wr_en` edge to the register output.
- Read latency is 0 cycles, combinational from `rd_addr` to `out`.
- Scan timeline, with `scan_start` sampled at edge 0:
  - Cycles 1 to 4 are in SCAN, with `scan_idx` = 0, 1, 2, 3 and `scan_valid` = 1.
  - Cycle 5 is DONE: `scan_done` = 1 and `scan_busy` = 0.
- Back-to-back scans: `scan_start` held high in DONE re-enters SCAN at cycle 6. The gap between scans is exactly one DONE cycle.
- `rd_addr` is ignored for `sel` during cycles 1 to 4.

## Structure
- Shared package `reg_bank_pkg` holds:
  - the `WIDTH` and `NREGS` constants;
  - FSM state encodings: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
- One sub-module: the existing `mux4way16`, instanced with the four entries on `a`–`d`, `sel` on its select, and `out` on its output. The output select is not re-implemented inline.

## Test plan
- **Reset values:** `rst` for 2 cycles, then release → `a`–`d` = 16'h0000, `scan_busy` = 0, `scan_done` = 0, `out` = 0 for every `rd_addr`.
- **Write/read:** write 16'h1111, 16'h2222, 16'h3333 and 16'hBEEF to entries 0 to 3, then sweep `rd_addr` 0 to 3 → `out` = the same values, each visible one cycle after its write.
- **Scan:** pulse `scan_start` with `rd_addr` held at 2 →
  - cycles 1 to 4: `scan_idx` = 0..3, `out` = 1111, 2222, 3333, BEEF;
  - cycle 5: `scan_done` = 1;
  - cycle 6: IDLE with `sel` = 2.
- **Collisions:** `clr_all` and `wr_en` (entry 1, 16'hAAAA) in the same cycle → all entries 0. Separately, `scan_start` asserted in cycle 2 of a scan → ignored, `scan_done` still at cycle 5.
- **Write during scan:** write entry 3 = 16'h5A5A in scan cycle 2 → `out` = 5A5A in scan cycle 4.
- **Reset mid-scan:** `rst` asserted in scan cycle 3 → next cycle IDLE, entries 0, no `scan_done` pulse. A new `scan_start` after release completes normally.
